// File: rtl/ibex_trace_buffer.sv
// ibex_trace_buffer: RVFI retirement trace capture into a Depth-entry circular
// buffer, drained over a valid/ready stream. Stream mode drains while capturing
// and counts dropped records; ring mode keeps the newest Depth records and
// freezes a programmable number of retirements after a PC trigger.
// Optional macro IBEX_TRACE_BUF_TIMESTAMP_EN adds a 32-bit cycle timestamp per record.
module ibex_trace_buffer #(
  parameter int unsigned Depth    = 16,
  parameter int unsigned SeqWidth = 16,
  parameter int unsigned OvfWidth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic                     mode_i,
  input  logic                     clear_i,
  input  logic                     trig_en_i,
  input  logic [31:0]              trig_pc_i,
  input  logic [$clog2(Depth):0]   post_trig_i,
  input  logic                     rvfi_valid,
  input  logic [63:0]              rvfi_order,
  input  logic [31:0]              rvfi_insn,
  input  logic                     rvfi_trap,
  input  logic                     rvfi_intr,
  input  logic [31:0]              rvfi_pc_rdata,
  input  logic [4:0]               rvfi_rd_addr,
  input  logic [31:0]              rvfi_rd_wdata,
  input  logic [31:0]              rvfi_mem_addr,
  input  logic [3:0]               rvfi_mem_rmask,
  input  logic [3:0]               rvfi_mem_wmask,
  output logic                     trace_valid_o,
  input  logic                     trace_ready_i,
  output logic [31:0]              trace_pc_o,
  output logic [31:0]              trace_insn_o,
  output logic [4:0]               trace_rd_addr_o,
  output logic [31:0]              trace_rd_wdata_o,
  output logic [31:0]              trace_mem_addr_o,
  output logic [3:0]               trace_flags_o,
  output logic [SeqWidth-1:0]      trace_seq_o,
  output logic [31:0]              trace_time_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic [OvfWidth-1:0]      overflow_cnt_o,
  output logic                     triggered_o,
  output logic                     frozen_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    ST_DISABLED,
    ST_CAPTURE,
    ST_POST,
    ST_FROZEN
  } state_e;

  state_e          state_q, state_d;
  logic            mode_q, mode_d;     // 0 = stream, 1 = ring
  logic [CW-1:0]   rem_q, rem_d;
  logic            push, trig_set;

  logic [AW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q, count_d;
  logic [OvfWidth-1:0] ovf_q;
  logic            trig_q;
  logic            full, pop, wr_en, drop, ring_ovw, head_adv;

  logic [31:0]         pc_mem    [Depth];
  logic [31:0]         insn_mem  [Depth];
  logic [4:0]          rd_mem    [Depth];
  logic [31:0]         wdata_mem [Depth];
  logic [31:0]         maddr_mem [Depth];
  logic [3:0]          flags_mem [Depth];
  logic [SeqWidth-1:0] seq_mem   [Depth];

  logic unused_order;
  assign unused_order = ^rvfi_order;

  // State, latched mode and post-trigger countdown registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_DISABLED;
      mode_q  <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
    end
  end

  // Next-state logic; clear_i overrides every other transition
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    rem_d    = rem_q;
    trig_set = 1'b0;
    push     = rvfi_valid & ((state_q == ST_CAPTURE) | (state_q == ST_POST));
    if (clear_i) begin
      state_d = enable_i ? ST_CAPTURE : ST_DISABLED;
      rem_d   = '0;
      if (enable_i) mode_d = mode_i;
    end else begin
      unique case (state_q)
        ST_DISABLED: begin
          if (enable_i) begin
            state_d = ST_CAPTURE;
            mode_d  = mode_i;
          end
        end
        ST_CAPTURE: begin
          if (mode_q && trig_en_i && rvfi_valid && (rvfi_pc_rdata == trig_pc_i)) begin
            trig_set = 1'b1;
            if (post_trig_i == '0) begin
              state_d = ST_FROZEN;
            end else begin
              state_d = ST_POST;
              rem_d   = post_trig_i;
            end
          end else if (!enable_i) begin
            state_d = ST_DISABLED;
          end
        end
        ST_POST: begin
          if (push) begin
            rem_d = rem_q - 1'b1;
            if (rem_q == CW'(1)) state_d = ST_FROZEN;
          end
          if (!enable_i) state_d = ST_FROZEN;
        end
        default: state_d = ST_FROZEN;
      endcase
    end
  end

  assign trace_valid_o = (count_q != '0) & (~mode_q | (state_q == ST_FROZEN));

  // Buffer bookkeeping: ring mode never pops while capturing, so a ring push
  // into a full buffer simply slides the window (head and tail both advance)
  always_comb begin
    full     = (count_q == CW'(Depth));
    pop      = trace_valid_o & trace_ready_i;
    wr_en    = push & ~clear_i & (mode_q | ~full | pop);
    drop     = push & ~clear_i & ~mode_q & full & ~pop;
    ring_ovw = wr_en & mode_q & full;
    head_adv = pop | ring_ovw;
    count_d  = count_q + CW'(wr_en & ~ring_ovw) - CW'(pop);
  end

  // Pointers, occupancy, overflow counter and trigger flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= '0;
      trig_q  <= 1'b0;
    end else if (clear_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= '0;
      trig_q  <= 1'b0;
    end else begin
      if (head_adv) head_q <= head_q + 1'b1;
      if (wr_en)    tail_q <= tail_q + 1'b1;
      count_q <= count_d;
      if (drop && (ovf_q != '1)) ovf_q <= ovf_q + 1'b1;
      if (trig_set) trig_q <= 1'b1;
    end
  end

  // Record storage; reset so that the data outputs read zero after reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        pc_mem[i]    <= '0;
        insn_mem[i]  <= '0;
        rd_mem[i]    <= '0;
        wdata_mem[i] <= '0;
        maddr_mem[i] <= '0;
        flags_mem[i] <= '0;
        seq_mem[i]   <= '0;
      end
    end else if (wr_en) begin
      pc_mem[tail_q]    <= rvfi_pc_rdata;
      insn_mem[tail_q]  <= rvfi_insn;
      rd_mem[tail_q]    <= rvfi_rd_addr;
      wdata_mem[tail_q] <= rvfi_rd_wdata;
      maddr_mem[tail_q] <= rvfi_mem_addr;
      flags_mem[tail_q] <= {rvfi_trap, rvfi_intr, |rvfi_mem_rmask, |rvfi_mem_wmask};
      seq_mem[tail_q]   <= rvfi_order[SeqWidth-1:0];
    end
  end

  assign trace_pc_o       = pc_mem[head_q];
  assign trace_insn_o     = insn_mem[head_q];
  assign trace_rd_addr_o  = rd_mem[head_q];
  assign trace_rd_wdata_o = wdata_mem[head_q];
  assign trace_mem_addr_o = maddr_mem[head_q];
  assign trace_flags_o    = flags_mem[head_q];
  assign trace_seq_o      = seq_mem[head_q];
  assign count_o          = count_q;
  assign overflow_cnt_o   = ovf_q;
  assign triggered_o      = trig_q;
  assign frozen_o         = (state_q == ST_FROZEN);

`ifdef IBEX_TRACE_BUF_TIMESTAMP_EN
  logic [31:0] time_q;
  logic [31:0] time_mem [Depth];

  // Free-running cycle counter, zeroed by clear_i
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        time_q <= '0;
    else if (clear_i) time_q <= '0;
    else              time_q <= time_q + 1'b1;
  end

  // Timestamp stored alongside each accepted record
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < Depth; i++) time_mem[i] <= '0;
    end else if (wr_en) begin
      time_mem[tail_q] <= time_q;
    end
  end

  assign trace_time_o = time_mem[head_q];
`else
  assign trace_time_o = '0;
`endif

endmodule

// File: tb/tb_ibex_trace_buffer.sv
// Testbench for ibex_trace_buffer: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_ibex_trace_buffer;

  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable, mode, clear, trig_en;
  logic [31:0]   trig_pc;
  logic [CW-1:0] post_trig;
  logic          rvfi_valid;
  logic [63:0]   rvfi_order;
  logic [31:0]   rvfi_insn;
  logic          rvfi_trap, rvfi_intr;
  logic [31:0]   rvfi_pc_rdata, rvfi_rd_wdata, rvfi_mem_addr;
  logic [4:0]    rvfi_rd_addr;
  logic [3:0]    rvfi_mem_rmask, rvfi_mem_wmask;
  logic          trace_valid, trace_ready;
  logic [31:0]   trace_pc, trace_insn, trace_rd_wdata, trace_mem_addr, trace_time;
  logic [4:0]    trace_rd_addr;
  logic [3:0]    trace_flags;
  logic [15:0]   trace_seq, overflow_cnt;
  logic [CW-1:0] count;
  logic          triggered, frozen;

  always #5 clk = ~clk;

  ibex_trace_buffer #(.Depth(DEPTH), .SeqWidth(16), .OvfWidth(16)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .mode_i(mode), .clear_i(clear),
    .trig_en_i(trig_en), .trig_pc_i(trig_pc), .post_trig_i(post_trig),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
    .rvfi_trap(rvfi_trap), .rvfi_intr(rvfi_intr), .rvfi_pc_rdata(rvfi_pc_rdata),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
    .rvfi_mem_wmask(rvfi_mem_wmask),
    .trace_valid_o(trace_valid), .trace_ready_i(trace_ready),
    .trace_pc_o(trace_pc), .trace_insn_o(trace_insn), .trace_rd_addr_o(trace_rd_addr),
    .trace_rd_wdata_o(trace_rd_wdata), .trace_mem_addr_o(trace_mem_addr),
    .trace_flags_o(trace_flags), .trace_seq_o(trace_seq), .trace_time_o(trace_time),
    .count_o(count), .overflow_cnt_o(overflow_cnt), .triggered_o(triggered),
    .frozen_o(frozen)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: a queue of records plus a few mode/phase flags
  typedef struct {
    logic [31:0] pc, insn, wdata, maddr, tm;
    logic [4:0]  rd;
    logic [3:0]  flags;
    logic [15:0] seq;
  } rec_t;

  rec_t        q[$];
  bit          m_ring, m_cap, m_frozen, m_trig;
  int          m_post_left;
  int          m_ovf;
  logic [31:0] m_time;
  logic [31:0] g_order;

  function automatic bit m_valid();
    return (q.size() != 0) && (!m_ring || m_frozen);
  endfunction

  task automatic model_reset();
    q.delete();
    m_ring = 0; m_cap = 0; m_frozen = 0; m_trig = 0;
    m_post_left = 0; m_ovf = 0; m_time = 0;
  endtask

  // Applies one clock edge worth of behaviour to the model
  task automatic model_update();
    bit   pop, pushing;
    rec_t r;
    pop = m_valid() && trace_ready;
    if (clear) begin
      q.delete();
      m_ovf = 0; m_trig = 0; m_frozen = 0; m_post_left = 0;
      m_cap = enable;
      if (enable) m_ring = mode;
      m_time = 0;
      return;
    end
    pushing = rvfi_valid && m_cap;
    r.pc = rvfi_pc_rdata; r.insn = rvfi_insn; r.wdata = rvfi_rd_wdata;
    r.maddr = rvfi_mem_addr; r.rd = rvfi_rd_addr; r.tm = m_time;
    r.flags = {rvfi_trap, rvfi_intr, rvfi_mem_rmask != 0, rvfi_mem_wmask != 0};
    r.seq = rvfi_order[15:0];
    if (pop) void'(q.pop_front());
    if (pushing) begin
      if (!m_ring) begin
        if (q.size() < DEPTH) q.push_back(r);
        else if (m_ovf < 65535) m_ovf++;
      end else begin
        q.push_back(r);
        if (q.size() > DEPTH) void'(q.pop_front());
      end
    end
    if (m_frozen) begin
      // only clear leaves the frozen phase
    end else if (!m_cap) begin
      if (enable) begin m_cap = 1; m_ring = mode; end
    end else if (m_post_left > 0) begin
      if (pushing) begin
        m_post_left--;
        if (m_post_left == 0) begin m_cap = 0; m_frozen = 1; end
      end
      if (!enable) begin m_cap = 0; m_frozen = 1; m_post_left = 0; end
    end else if (m_ring && trig_en && rvfi_valid && rvfi_pc_rdata == trig_pc) begin
      m_trig = 1;
      if (post_trig == 0) begin m_cap = 0; m_frozen = 1; end
      else m_post_left = int'(post_trig);
    end else if (!enable) begin
      m_cap = 0;
    end
    m_time = m_time + 1;
  endtask

  task automatic compare_all();
    bit mv;
    mv = m_valid();
    check_eq("count", 64'(count), 64'(q.size()));
    check_eq("valid", 64'(trace_valid), 64'(mv));
    check_eq("ovf", 64'(overflow_cnt), 64'(m_ovf));
    check_eq("triggered", 64'(triggered), 64'(m_trig));
    check_eq("frozen", 64'(frozen), 64'(m_frozen));
    if (mv) begin
      check_eq("pc", 64'(trace_pc), 64'(q[0].pc));
      check_eq("insn", 64'(trace_insn), 64'(q[0].insn));
      check_eq("rd", 64'(trace_rd_addr), 64'(q[0].rd));
      check_eq("wdata", 64'(trace_rd_wdata), 64'(q[0].wdata));
      check_eq("maddr", 64'(trace_mem_addr), 64'(q[0].maddr));
      check_eq("flags", 64'(trace_flags), 64'(q[0].flags));
      check_eq("seq", 64'(trace_seq), 64'(q[0].seq));
`ifdef IBEX_TRACE_BUF_TIMESTAMP_EN
      check_eq("time", 64'(trace_time), 64'(q[0].tm));
`else
      check_eq("time", 64'(trace_time), 64'd0);
`endif
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_valid"}, 64'(trace_valid), 0);
    check_eq({tag, "_count"}, 64'(count), 0);
    check_eq({tag, "_ovf"}, 64'(overflow_cnt), 0);
    check_eq({tag, "_trig"}, 64'(triggered), 0);
    check_eq({tag, "_frozen"}, 64'(frozen), 0);
    check_eq({tag, "_data"}, 64'({trace_pc, trace_insn} | 64'(trace_rd_wdata)
             | 64'(trace_mem_addr) | 64'(trace_rd_addr) | 64'(trace_flags)
             | 64'(trace_seq) | 64'(trace_time)), 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive_ret(input logic v, input logic [31:0] pc);
    rvfi_valid     = v;
    rvfi_pc_rdata  = pc;
    rvfi_order     = {32'($urandom), g_order};
    rvfi_insn      = $urandom;
    rvfi_trap      = 1'($urandom);
    rvfi_intr      = 1'($urandom);
    rvfi_rd_addr   = 5'($urandom);
    rvfi_rd_wdata  = $urandom;
    rvfi_mem_addr  = $urandom;
    rvfi_mem_rmask = 4'($urandom);
    rvfi_mem_wmask = 4'($urandom);
    if (v) g_order++;
  endtask

  task automatic do_clear(input logic en, input logic md);
    enable = en; mode = md; clear = 1'b1;
    drive_ret(1'b0, 32'h0);
    step();
    clear = 1'b0;
    g_order = 0;
  endtask

  initial begin
    rst = 1'b1; enable = 0; mode = 0; clear = 0; trig_en = 0; trig_pc = 32'h200;
    post_trig = '0; trace_ready = 0; g_order = 0;
    drive_ret(1'b0, 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Stream: 5 retirements drained immediately
    enable = 1; mode = 0; trace_ready = 1;
    drive_ret(1'b0, 0); step();
    for (int i = 0; i < 5; i++) begin drive_ret(1'b1, 32'h100 + 32'(4 * i)); step(); end
    drive_ret(1'b0, 0);
    repeat (3) step();

    // Stream: fill past full with no sink, then push+pop while full, then drain
    trace_ready = 0;
    do_clear(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin drive_ret(1'b1, 32'h400 + 32'(4 * i)); step(); end
    trace_ready = 1; drive_ret(1'b1, 32'h500); step();
    drive_ret(1'b0, 0);
    repeat (18) step();

    // Ring: trigger at index 20 with three post-trigger retirements
    trace_ready = 0; trig_en = 1; trig_pc = 32'h200; post_trig = 5'd3;
    do_clear(1'b1, 1'b1);
    for (int i = 0; i < 30; i++) begin
      drive_ret(1'b1, (i == 20) ? 32'h200 : 32'h1000 + 32'(4 * i)); step();
    end
    drive_ret(1'b0, 0);
    for (int i = 0; i < 20; i++) begin trace_ready = 1'($urandom); step(); end
    trace_ready = 1;
    repeat (17) step();

    // Ring: immediate freeze on the first retirement, later ones ignored
    trace_ready = 0; post_trig = '0;
    do_clear(1'b1, 1'b1);
    drive_ret(1'b1, 32'h200); step();
    for (int i = 0; i < 4; i++) begin drive_ret(1'b1, 32'h300 + 32'(4 * i)); step(); end
    drive_ret(1'b0, 0);
    do_clear(1'b1, 1'b1);
    drive_ret(1'b1, 32'h300); step();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      enable      = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 9) == 0) mode = 1'($urandom);
      clear       = ($urandom_range(0, 59) == 0);
      trig_en     = 1'($urandom);
      post_trig   = 5'($urandom_range(0, 18));
      trace_ready = ($urandom_range(0, 2) != 0);
      drive_ret(1'($urandom),
                ($urandom_range(0, 11) == 0) ? 32'h200 : {$urandom_range(0, 1023), 2'b00});
      step();
    end
    clear = 0;

    // Asynchronous reset while draining seven records
    trace_ready = 0; trig_en = 0;
    do_clear(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin drive_ret(1'b1, 32'h700 + 32'(4 * i)); step(); end
    drive_ret(1'b0, 0); trace_ready = 1; step();
    check_eq("pre_reset_count", 64'(count), 64'd7);
    #2 rst = 1'b1;
    #1 check_zero("async_reset");
    model_reset();
    enable = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ibex_trace_buffer.md
Name: ibex_trace_buffer

Overview:
- Parametrised on-chip retirement trace capture for ibex_top.
- Consumes the RVFI retirement stream and stores compact records in a Depth-entry circular buffer.
- Drains records over a valid/ready stream to a debug/DMA sink.
- Two modes: lossless-drain stream mode with overflow accounting; ring mode with a PC trigger and post-trigger freeze, for post-mortem capture.

Parameters:
Depth, 16, buffer entries; power of two, >= 2
SeqWidth, 16, low bits of rvfi_order carried per record
OvfWidth, 16, width of the saturating overflow counter

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
enable_i  in  1  capture enable
mode_i  in  1  0 = stream, 1 = ring; latched on entry to CAPTURE
clear_i  in  1  synchronous flush
trig_en_i  in  1  ring-mode trigger enable
trig_pc_i  in  32  trigger PC
post_trig_i  in  $clog2(Depth)+1  retirements captured after the trigger
rvfi_valid  in  1  retirement strobe
rvfi_order  in  64  retirement index
rvfi_insn  in  32  instruction
rvfi_trap  in  1  trap flag
rvfi_intr  in  1  interrupt flag
rvfi_pc_rdata  in  32  retired PC
rvfi_rd_addr  in  5  destination register
rvfi_rd_wdata  in  32  writeback data
rvfi_mem_addr  in  32  memory address
rvfi_mem_rmask  in  4  load mask
rvfi_mem_wmask  in  4  store mask
trace_valid_o  out  1  record available
trace_ready_i  in  1  sink accepts
trace_pc_o  out  32  record PC
trace_insn_o  out  32  record instruction
trace_rd_addr_o  out  5  record rd
trace_rd_wdata_o  out  32  record rd data
trace_mem_addr_o  out  32  record memory address
trace_flags_o  out  4  {trap, intr, |rmask, |wmask}
trace_seq_o  out  SeqWidth  rvfi_order[SeqWidth-1:0]
trace_time_o  out  32  cycle timestamp (see Optional Feature)
count_o  out  $clog2(Depth)+1  occupancy
overflow_cnt_o  out  OvfWidth  dropped records, saturating
triggered_o  out  1  trigger has fired
frozen_o  out  1  state == FROZEN

Behaviour:
Reset and interface rules
- Reset (rst_i high, asynchronous):
  - state = DISABLED; head = tail = count = 0.
  - overflow_cnt_o = 0, triggered_o = 0, frozen_o = 0, trace_valid_o = 0.
  - All trace_* data outputs = 0; latched mode = stream.
- Reset mid-operation discards all contents immediately.
- Push: on a rising edge with rvfi_valid high while state is CAPTURE or POST.
- Pop: trace_valid_o & trace_ready_i.
- trace_valid_o = (count != 0) & (mode == stream | state == FROZEN).
  - No drain in ring mode until frozen.
- trace_* outputs are driven from buffer[head]. They are held stable while valid & !ready.
- Latency: a record pushed at edge N is visible on trace_valid_o after edge N (earliest pop at N+1).

States
- DISABLED
  - Goes to CAPTURE when enable_i = 1; latches mode_i on that transition.
  - Contents are retained. Stream-mode drain continues.
- CAPTURE
  - Goes to DISABLED when enable_i = 0.
  - Ring mode, trig_en_i = 1, rvfi_valid = 1 and rvfi_pc_rdata == trig_pc_i:
    - The triggering record is pushed and triggered_o is set.
    - Next state is FROZEN if post_trig_i == 0; otherwise POST, with remaining = post_trig_i.
- POST
  - Each push decrements remaining.
  - The push that takes remaining to 0 is stored, then state goes to FROZEN.
  - enable_i = 0 goes to FROZEN.
- FROZEN
  - No pushes; drain allowed.
  - Stays frozen, including when empty, until clear_i.

Full and overflow
- Stream mode, full, push with no pop: record dropped; overflow_cnt_o increments, saturating at all-ones.
- Stream mode, full, push with simultaneous pop: both take effect; count unchanged, no drop.
- Ring mode, full, push: overwrites the oldest record; head and tail both advance; count stays Depth. Not counted as overflow.
- Pointers wrap modulo Depth. count ranges 0..Depth.

clear_i
- Takes priority over push, pop and trigger in the same cycle.
- Zeroes head, tail, count, overflow_cnt_o and triggered_o.
- Next state is CAPTURE (re-latching mode_i) if enable_i = 1; otherwise DISABLED.

Optional Feature:
- Macro: IBEX_TRACE_BUF_TIMESTAMP_EN.
- Defined:
  - A 32-bit free-running cycle counter runs, reset to 0 and wrapping at 2^32.
  - Each push stores the counter value with the record, presented on trace_time_o.
  - clear_i zeroes the counter.
- Undefined:
  - No counter or timestamp storage is built; trace_time_o is tied to 0.

Test Plan:
- Stream, Depth=16: 5 retirements with PCs 0x100..0x110 step 4, trace_ready_i=1 -> 5 records in order, trace_seq_o=0..4, count_o returns to 0, overflow_cnt_o=0.
- Stream, trace_ready_i=0: 20 retirements -> count_o=16, overflow_cnt_o=4, drained records are seq 0..15.
- Stream, full, rvfi_valid and pop in the same cycle -> count_o stays 16, overflow_cnt_o unchanged, new record appears last.
- Ring, trig_pc_i=0x200, post_trig_i=3: 30 retirements with the trigger at index 20 -> frozen_o after index 23; drain yields 16 records, seq 8..23; triggered_o=1.
- Ring, post_trig_i=0, trigger on the first retirement -> FROZEN next cycle, count_o=1; later retirements ignored; clear_i -> count_o=0, triggered_o=0, state CAPTURE.
- rst_i asserted mid-drain with count_o=7 -> all outputs 0 asynchronously; with IBEX_TRACE_BUF_TIMESTAMP_EN, timestamps of back-to-back retirements differ by 1.
